// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types for the pipeline hazard unit
package hazard_pkg;

  localparam int REG_AW = 3;

  typedef enum logic [1:0] {
    RF    = 2'b00,
    WB    = 2'b01,
    MEM_A = 2'b10,
    MEM_B = 2'b11
  } fwd_sel_t;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - forwarding source select for one ALU operand
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] wa3m,
  input  logic [REG_AW-1:0] wa4m,
  input  logic [REG_AW-1:0] wa3w,
  input  logic              reg_write_am,
  input  logic              reg_write_bm,
  input  logic              reg_write_aw,
  output logic [1:0]        fwd
);

  fwd_sel_t sel;

  // Youngest producer wins: memory port A, then memory port B, then writeback.
  always_comb begin
    sel = RF;
    if (reg_write_am && (wa3m == ra))
      sel = MEM_A;
    else if (reg_write_bm && (wa4m == ra))
      sel = MEM_B;
    else if (reg_write_aw && (wa3w == ra))
      sel = WB;
  end

  assign fwd = sel;

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - stall/flush/forward control; HAZARD_PERF_EN adds the StallCnt counter
module hazard_unit
  import hazard_pkg::*;
#(
  parameter logic [7:0] WAIT_MAX = 8'd200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] RA1E,
  input  logic [REG_AW-1:0] RA2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic              RegWriteAE,
  input  logic              MemtoRegE,
  input  logic [REG_AW-1:0] WA3M,
  input  logic [REG_AW-1:0] WA4M,
  input  logic              RegWriteAM,
  input  logic              RegWriteBM,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              RegWriteAW,
  input  logic              BranchTakenE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MemTimeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]       StallCnt
`endif
);

  hz_state_t  state;
  logic [7:0] wait_cnt;
  logic [7:0] wait_inc;
  logic       mem_stall;
  logic       load_use;

  hazard_fwd_sel u_fwd_a (
    .ra           (RA1E),
    .wa3m         (WA3M),
    .wa4m         (WA4M),
    .wa3w         (WA3W),
    .reg_write_am (RegWriteAM),
    .reg_write_bm (RegWriteBM),
    .reg_write_aw (RegWriteAW),
    .fwd          (ForwardAE)
  );

  hazard_fwd_sel u_fwd_b (
    .ra           (RA2E),
    .wa3m         (WA3M),
    .wa4m         (WA4M),
    .wa3w         (WA3W),
    .reg_write_am (RegWriteAM),
    .reg_write_bm (RegWriteBM),
    .reg_write_aw (RegWriteAW),
    .fwd          (ForwardBE)
  );

  assign mem_stall = !MemReadyM && ((state == MEMWAIT) || MemReqM);
  assign load_use  = MemtoRegE && RegWriteAE && ((WA3E == RA1D) || (WA3E == RA2D));
  assign wait_inc  = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;

  // Memory stall dominates; a branch seen while held is re-presented at release.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (rst_n) begin
      if (mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
      end else if (BranchTakenE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      wait_cnt   <= 8'd0;
      MemTimeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          wait_cnt <= 8'd0;
          if (MemReqM && !MemReadyM)
            state <= MEMWAIT;
        end
        MEMWAIT: begin
          wait_cnt <= wait_inc;
          if (wait_inc == WAIT_MAX)
            MemTimeout <= 1'b1;
          if (MemReadyM)
            state <= RUN;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      StallCnt <= 16'd0;
    else if (StallD && (StallCnt != 16'hFFFF))
      StallCnt <= StallCnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA4M, WA3W;
  logic       RegWriteAE, MemtoRegE, RegWriteAM, RegWriteBM, RegWriteAW;
  logic       BranchTakenE, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, FlushD, FlushE, MemTimeout;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
  logic [15:0] StallCnt;
`endif

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  hazard_unit #(.WAIT_MAX(8'd3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .RA1D         (RA1D),
    .RA2D         (RA2D),
    .RA1E         (RA1E),
    .RA2E         (RA2E),
    .WA3E         (WA3E),
    .RegWriteAE   (RegWriteAE),
    .MemtoRegE    (MemtoRegE),
    .WA3M         (WA3M),
    .WA4M         (WA4M),
    .RegWriteAM   (RegWriteAM),
    .RegWriteBM   (RegWriteBM),
    .WA3W         (WA3W),
    .RegWriteAW   (RegWriteAW),
    .BranchTakenE (BranchTakenE),
    .MemReqM      (MemReqM),
    .MemReadyM    (MemReadyM),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .MemTimeout   (MemTimeout)
`ifdef HAZARD_PERF_EN
    ,
    .StallCnt     (StallCnt)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic sf, input logic sd, input logic se,
                         input logic fd, input logic fe);
    chk({tag, ".StallF"}, {15'd0, StallF}, {15'd0, sf});
    chk({tag, ".StallD"}, {15'd0, StallD}, {15'd0, sd});
    chk({tag, ".StallE"}, {15'd0, StallE}, {15'd0, se});
    chk({tag, ".FlushD"}, {15'd0, FlushD}, {15'd0, fd});
    chk({tag, ".FlushE"}, {15'd0, FlushE}, {15'd0, fe});
  endtask

  task automatic chk_cnt(input string tag);
`ifdef HAZARD_PERF_EN
    chk(tag, StallCnt, exp_cnt[15:0]);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA4M, WA3W} = '0;
    {RegWriteAE, MemtoRegE, RegWriteAM, RegWriteBM, RegWriteAW} = '0;
    {BranchTakenE, MemReqM, MemReadyM} = '0;
    #2;
    chk_ctl("reset", 0, 0, 0, 0, 0);
    chk("reset.ForwardAE", {14'd0, ForwardAE}, 16'd0);
    chk("reset.MemTimeout", {15'd0, MemTimeout}, 16'd0);
    chk_cnt("reset.StallCnt");
    MemReqM = 1'b1;
    #1;
    chk_ctl("reset_memreq", 0, 0, 0, 0, 0);
    MemReqM = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Forwarding priority
    RA1E = 3'd3; RA2E = 3'd4; WA3M = 3'd3; WA4M = 3'd4; WA3W = 3'd3;
    RegWriteAM = 1'b1; RegWriteBM = 1'b1; RegWriteAW = 1'b1;
    #1;
    chk("fwd_memA.ForwardAE", {14'd0, ForwardAE}, 16'h2);
    chk("fwd_memB.ForwardBE", {14'd0, ForwardBE}, 16'h3);
    RegWriteAM = 1'b0;
    #1;
    chk("fwd_wb.ForwardAE", {14'd0, ForwardAE}, 16'h1);
    chk("fwd_memB2.ForwardBE", {14'd0, ForwardBE}, 16'h3);
    RegWriteBM = 1'b0;
    #1;
    chk("fwd_rf.ForwardBE", {14'd0, ForwardBE}, 16'h0);
    WA3M = 3'd4; RegWriteAM = 1'b1; RegWriteBM = 1'b1;
    #1;
    chk("fwd_AoverB.ForwardBE", {14'd0, ForwardBE}, 16'h2);
    RegWriteAM = 1'b0; RegWriteBM = 1'b0; RegWriteAW = 1'b0;
    tick();

    // Load-use
    MemtoRegE = 1'b1; RegWriteAE = 1'b1; WA3E = 3'd5; RA2D = 3'd5; RA1D = 3'd1;
    #1;
    chk_ctl("loaduse", 1, 1, 0, 0, 1);
    tick();
    exp_cnt = exp_cnt + 1;
    MemtoRegE = 1'b0;
    #1;
    chk_ctl("loaduse_next", 0, 0, 0, 0, 0);
    chk_cnt("loaduse.StallCnt");
    MemtoRegE = 1'b1; RegWriteAE = 1'b0;
    #1;
    chk_ctl("load_nowrite", 0, 0, 0, 0, 0);
    RegWriteAE = 1'b1; RA2D = 3'd0; RA1D = 3'd5;
    #1;
    chk_ctl("loaduse_ra1", 1, 1, 0, 0, 1);

    // Branch overrides load-use
    BranchTakenE = 1'b1;
    #1;
    chk_ctl("branch_loaduse", 0, 0, 0, 1, 1);
    tick();
    BranchTakenE = 1'b0; MemtoRegE = 1'b0; RegWriteAE = 1'b0;
    tick();

    // Memory stall of 4 cycles with a branch arriving mid-stall
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) BranchTakenE = 1'b1;
      #1;
      chk_ctl($sformatf("memstall%0d", i), 1, 1, 1, 0, 0);
      tick();
      exp_cnt = exp_cnt + 1;
    end
    MemReadyM = 1'b1;
    #1;
    chk_ctl("mem_release", 0, 0, 0, 1, 1);
    chk("mem_release.MemTimeout", {15'd0, MemTimeout}, 16'd1);
    chk_cnt("mem_release.StallCnt");
    tick();
    chk_cnt("after_release.StallCnt");
    MemReqM = 1'b0; MemReadyM = 1'b0; BranchTakenE = 1'b0;
    #1;
    chk_ctl("idle", 0, 0, 0, 0, 0);

    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("rst2.MemTimeout", {15'd0, MemTimeout}, 16'd0);
    chk_cnt("rst2.StallCnt");
    tick();
    rst_n = 1'b1;
    tick();

    // Timeout after the third MEMWAIT cycle, sticky past release
    MemReqM = 1'b1; MemReadyM = 1'b0;
    tick();
    tick();
    chk("to_w1.MemTimeout", {15'd0, MemTimeout}, 16'd0);
    tick();
    chk("to_w2.MemTimeout", {15'd0, MemTimeout}, 16'd0);
    tick();
    chk("to_w3.MemTimeout", {15'd0, MemTimeout}, 16'd1);
    chk_ctl("to_w3", 1, 1, 1, 0, 0);
    MemReadyM = 1'b1;
    #1;
    chk_ctl("to_release", 0, 0, 0, 0, 0);
    tick();
    MemReqM = 1'b0; MemReadyM = 1'b0;
    #1;
    chk("to_sticky.MemTimeout", {15'd0, MemTimeout}, 16'd1);
    chk_ctl("to_run", 0, 0, 0, 0, 0);

    // Reset pulse mid-wait aborts the wait
    MemReqM = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_ctl("rst_midwait", 0, 0, 0, 0, 0);
    chk("rst_midwait.MemTimeout", {15'd0, MemTimeout}, 16'd0);
    MemReqM = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk_ctl("post_rst_run", 0, 0, 0, 0, 0);
    tick();
    chk_ctl("post_rst_run2", 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter: WAIT_MAX, 8'd200, memory-wait cycles at which MemTimeout sets; legal range 1..255.
REQ-002 Ports, in order (name direction width meaning):
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- RA1D  in  3  decode-stage source register 1.
- RA2D  in  3  decode-stage source register 2.
- RA1E  in  3  execute-stage source register 1.
- RA2E  in  3  execute-stage source register 2.
- WA3E  in  3  execute-stage port-A destination.
- RegWriteAE  in  1  execute-stage port-A write enable.
- MemtoRegE  in  1  execute-stage instruction is a load.
- WA3M  in  3  memory-stage port-A destination.
- WA4M  in  3  memory-stage port-B destination.
- RegWriteAM  in  1  memory-stage port-A write enable.
- RegWriteBM  in  1  memory-stage port-B write enable.
- WA3W  in  3  writeback-stage port-A destination.
- RegWriteAW  in  1  writeback-stage port-A write enable.
- BranchTakenE  in  1  taken branch resolved in execute.
- MemReqM  in  1  memory-stage data access in progress.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF  out  1  hold PC.
- StallD  out  1  hold F/D register.
- StallE  out  1  hold E/M and M/W registers.
- FlushD  out  1  clear F/D register to NOP.
- FlushE  out  1  drive the execute pipe register's flush input (NOP).
- ForwardAE  out  2  ALU operand A source select.
- ForwardBE  out  2  ALU operand B source select.
- MemTimeout  out  1  sticky memory-wait timeout flag.
- StallCnt  out  16  stall-cycle count; present only under HAZARD_PERF_EN.

Function
REQ-003 Forward select encoding, per operand (RAxE): 2'b10 if RegWriteAM and WA3M==RAxE; else 2'b11 if RegWriteBM and WA4M==RAxE; else 2'b01 if RegWriteAW and WA3W==RAxE; else 2'b00 (register file). Priority is in that order. Forward selects are combinational and are never gated by stall or flush.
REQ-004 FSM states are RUN and MEMWAIT. RUN->MEMWAIT when MemReqM=1 and MemReadyM=0. MEMWAIT->RUN on the cycle MemReadyM=1.
REQ-005 Memory stall (Mealy): StallF=StallD=StallE=1 and FlushD=FlushE=0 whenever (state==MEMWAIT and !MemReadyM) or (state==RUN and MemReqM and !MemReadyM). All stalls release combinationally in the MemReadyM cycle.
REQ-006 Load-use (no memory stall active): if MemtoRegE and RegWriteAE and WA3E equals RA1D or RA2D, assert StallF=StallD=FlushE=1 for exactly that cycle.
REQ-007 Branch (no memory stall active): BranchTakenE asserts FlushD=FlushE=1 and forces StallF=StallD=0, overriding load-use in the same cycle.
REQ-008 Branch during a memory stall has no effect until release; the held execute stage re-presents BranchTakenE, and the flush occurs in the release cycle.
REQ-009 An 8-bit wait counter clears in RUN and increments each MEMWAIT cycle, saturating at 255. MemTimeout sets when the count reaches WAIT_MAX and stays set until reset. Timeout does not force an FSM exit.

Reset
REQ-010 rst_n=0 asynchronously forces: state=RUN, wait counter=0, MemTimeout=0, StallCnt=0.
REQ-011 While in reset, all stall and flush outputs are 0. A reset during MEMWAIT aborts the wait.

Configuration
REQ-012 Macro HAZARD_PERF_EN, when defined: StallCnt increments each cycle StallD=1 and saturates at 16'hFFFF.
REQ-013 Macro HAZARD_PERF_EN, when undefined: the StallCnt port and its counter do not exist. All other behaviour is identical.

Structure
REQ-014 Package hazard_pkg holds the fwd_sel_t enum (RF, WB, MEM_A, MEM_B), the hz_state_t enum, and REG_AW=3.
REQ-015 Sub-module hazard_fwd_sel (one operand's comparator/priority logic) is instantiated twice, once per ALU operand.

Verification
REQ-016 RA1E=3, WA3M=3, RegWriteAM=1, WA3W=3, RegWriteAW=1 -> ForwardAE=2'b10; then drop RegWriteAM -> 2'b01.
REQ-017 Load with WA3E=5, RA2D=5 -> one cycle of StallF=StallD=FlushE=1; next cycle all 0.
REQ-018 Load-use and BranchTakenE in the same cycle -> FlushD=FlushE=1, StallF=StallD=0.
REQ-019 MemReqM=1 with MemReadyM low for 4 cycles then high -> StallE=1 for 4 cycles and 0 on the 5th; StallCnt advances by 4 with HAZARD_PERF_EN.
REQ-020 WAIT_MAX=3 with MemReadyM held low -> MemTimeout=1 after the 3rd wait cycle and stays 1 after MemReadyM; rst_n pulse mid-wait -> state RUN, outputs 0.
